// File: rtl/issue_scheduler_pkg.sv
// rtl/issue_scheduler_pkg.sv - shared constants and FU class type for the issue scheduler
package issue_scheduler_pkg;

  localparam int RS_SIZE  = 16;
  localparam int MULT_LAT = 4;
  localparam int ALU_WB   = 1;

  typedef enum logic {
    FU_ALU  = 1'b0,
    FU_MULT = 1'b1
  } fu_class_e;

  // CDB slot offset after issue for a given functional unit class
  function automatic int wb_offset(input fu_class_e cls, input int alu_wb, input int mult_lat);
    return (cls == FU_MULT) ? mult_lat : alu_wb;
  endfunction

endpackage

// File: rtl/issue_scheduler_rr_picker.sv
// rtl/issue_scheduler_rr_picker.sv - rotating-priority one-hot selector (request vector + pointer)
module issue_scheduler_rr_picker #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] grant_o,
  output logic         valid_o,
  output logic [W-1:0] idx_o
);

  logic [W-1:0] cand;

  // Scan ptr, ptr+1, ... and keep the first requester; N is a power of 2 so W-bit add wraps
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      cand = ptr_i + W'(k);
      if (!valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

  // One-hot grant of the selected index
  always_comb begin
    grant_o = '0;
    if (valid_o) begin
      grant_o[idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/issue_scheduler.sv
// rtl/issue_scheduler.sv - single-issue RS select with MULT occupancy and CDB slot reservation (optional ISSUE_SCHED_STATS_EN counters)
module issue_scheduler
  import issue_scheduler_pkg::*;
#(
  parameter int RS_SIZE  = issue_scheduler_pkg::RS_SIZE,
  parameter int RS_IDX_W = $clog2(RS_SIZE),
  parameter int MULT_LAT = issue_scheduler_pkg::MULT_LAT,
  parameter int ALU_WB   = issue_scheduler_pkg::ALU_WB,
  parameter int RESV_W   = MULT_LAT + 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [RS_SIZE-1:0]  rs_ready,
  input  logic [RS_SIZE-1:0]  rs_is_mult,
  input  logic                ex_stall,
  input  logic                squash,
  output logic                issue_en,
  output logic [RS_IDX_W-1:0] issue_idx,
  output logic                issue_is_mult,
  output logic [RS_SIZE-1:0]  rs_clear,
`ifdef ISSUE_SCHED_STATS_EN
  output logic [31:0]         issue_count,
  output logic [31:0]         conflict_stall_count,
`endif
  output logic                mult_busy
);

  localparam int CNT_W = $clog2(MULT_LAT + 1);

  logic [RS_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]    mult_cnt_q, mult_cnt_d;
  logic [RESV_W-1:0]   resv_q, resv_d;

  logic                alu_ok;
  logic                mult_ok;
  logic [RS_SIZE-1:0]  eligible;
  logic [RS_SIZE-1:0]  grant;
  logic                pick_valid;
  logic [RS_IDX_W-1:0] pick_idx;
  fu_class_e           issue_class;

  // ALU needs its writeback slot free; MULT needs an idle multiplier and its slot free
  assign alu_ok  = !resv_q[ALU_WB];
  assign mult_ok = (mult_cnt_q == '0) && !resv_q[MULT_LAT];

  // Per-entry eligibility: a blocked class masks only its own entries
  always_comb begin
    eligible = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      eligible[i] = rs_ready[i] && !squash && !ex_stall && (rs_is_mult[i] ? mult_ok : alu_ok);
    end
  end

  issue_scheduler_rr_picker #(
    .N (RS_SIZE),
    .W (RS_IDX_W)
  ) u_rr_picker (
    .req_i   (eligible),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  assign issue_class   = (pick_valid && rs_is_mult[pick_idx]) ? FU_MULT : FU_ALU;
  assign issue_en      = pick_valid;
  assign issue_idx     = pick_valid ? pick_idx : '0;
  assign issue_is_mult = pick_valid && (issue_class == FU_MULT);
  assign rs_clear      = grant;
  assign mult_busy     = (mult_cnt_q != '0);

  // Next state: reservations and multiplier count drain every cycle; squash flushes all
  always_comb begin
    resv_d     = resv_q >> 1;
    mult_cnt_d = (mult_cnt_q != '0) ? (mult_cnt_q - CNT_W'(1)) : '0;
    rr_ptr_d   = rr_ptr_q;
    if (squash) begin
      resv_d     = '0;
      mult_cnt_d = '0;
      rr_ptr_d   = '0;
    end else if (issue_en) begin
      resv_d   = resv_d | (RESV_W'(1) << (wb_offset(issue_class, ALU_WB, MULT_LAT) - 1));
      rr_ptr_d = issue_idx + RS_IDX_W'(1);
      if (issue_class == FU_MULT) begin
        mult_cnt_d = CNT_W'(MULT_LAT - 1);
      end
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q   <= '0;
      mult_cnt_q <= '0;
      resv_q     <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      mult_cnt_q <= mult_cnt_d;
      resv_q     <= resv_d;
    end
  end

`ifdef ISSUE_SCHED_STATS_EN
  logic [31:0] issue_count_q;
  logic [31:0] conflict_q;

  // Issue and resource-conflict counters; squash leaves them alone
  always_ff @(posedge clock) begin
    if (reset) begin
      issue_count_q <= '0;
      conflict_q    <= '0;
    end else begin
      if (issue_en) begin
        issue_count_q <= issue_count_q + 32'd1;
      end
      if ((|rs_ready) && !squash && !ex_stall && !issue_en) begin
        conflict_q <= conflict_q + 32'd1;
      end
    end
  end

  assign issue_count          = issue_count_q;
  assign conflict_stall_count = conflict_q;
`endif

endmodule

// File: tb/tb_issue_scheduler.sv
// tb/tb_issue_scheduler.sv - table-driven bench for issue_scheduler
module tb_issue_scheduler;

  logic        clock;
  logic        reset;
  logic [15:0] rs_ready;
  logic [15:0] rs_is_mult;
  logic        ex_stall;
  logic        squash;
  logic        issue_en;
  logic [3:0]  issue_idx;
  logic        issue_is_mult;
  logic [15:0] rs_clear;
  logic        mult_busy;
`ifdef ISSUE_SCHED_STATS_EN
  logic [31:0] issue_count;
  logic [31:0] conflict_stall_count;
`endif

  issue_scheduler dut (
    .clock                (clock),
    .reset                (reset),
    .rs_ready             (rs_ready),
    .rs_is_mult           (rs_is_mult),
    .ex_stall             (ex_stall),
    .squash               (squash),
    .issue_en             (issue_en),
    .issue_idx            (issue_idx),
    .issue_is_mult        (issue_is_mult),
    .rs_clear             (rs_clear),
`ifdef ISSUE_SCHED_STATS_EN
    .issue_count          (issue_count),
    .conflict_stall_count (conflict_stall_count),
`endif
    .mult_busy            (mult_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic [15:0] ready;
    logic [15:0] mult;
    logic        stall;
    logic        sq;
    logic        en;
    logic [3:0]  idx;
    logic        ism;
    logic        busy;
  } vec_t;

  vec_t vecs[40];
  int   nvec;
  int   errors;
  int   checks;

  function automatic vec_t mk(input logic rst, input logic [15:0] ready, input logic [15:0] mult,
                              input logic stall, input logic sq, input logic en,
                              input logic [3:0] idx, input logic ism, input logic busy);
    vec_t v;
    v.rst = rst; v.ready = ready; v.mult = mult; v.stall = stall; v.sq = sq;
    v.en = en; v.idx = idx; v.ism = ism; v.busy = busy;
    return v;
  endfunction

  task automatic add(input vec_t v);
    vecs[nvec] = v;
    nvec++;
  endtask

  task automatic check(input string name, input int vi, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s vec%0d: got %0h want %0h", name, vi, got, want);
    end
  endtask

  initial begin
    logic [15:0] exp_clear;
    int          m_issue;
    int          m_conflict;

    errors = 0; checks = 0; nvec = 0;
    m_issue = 0; m_conflict = 0;

    //   rst  ready     mult      stl sq   en idx   ism busy
    // Outputs during reset follow the combinational rules on cleared state
    add(mk(1, 16'h0000, 16'h0000, 0, 0,  0, 4'd0, 0, 0));
    add(mk(1, 16'h0010, 16'h0000, 0, 0,  1, 4'd4, 0, 0));
    add(mk(1, 16'h0010, 16'h0010, 0, 0,  1, 4'd4, 1, 0));
    // Round robin over two ALU entries, then idle, then rr_ptr=5 visible
    add(mk(0, 16'h0011, 16'h0000, 0, 0,  1, 4'd0, 0, 0));
    add(mk(0, 16'h0010, 16'h0000, 0, 0,  1, 4'd4, 0, 0));
    add(mk(0, 16'h0000, 16'h0000, 0, 0,  0, 4'd0, 0, 0));
    add(mk(0, 16'h0021, 16'h0000, 0, 0,  1, 4'd5, 0, 0));
    add(mk(0, 16'h0001, 16'h0000, 0, 0,  1, 4'd0, 0, 0));
    // MULT at 2, next MULT at 3 held off for MULT_LAT cycles
    add(mk(0, 16'h000C, 16'h000C, 0, 0,  1, 4'd2, 1, 0));
    add(mk(0, 16'h0008, 16'h0008, 0, 0,  0, 4'd0, 0, 1));
    add(mk(0, 16'h0008, 16'h0008, 0, 0,  0, 4'd0, 0, 1));
    add(mk(0, 16'h0008, 16'h0008, 0, 0,  0, 4'd0, 0, 1));
    add(mk(0, 16'h0008, 16'h0008, 0, 0,  1, 4'd3, 1, 0));
    // Blocked MULT does not block ALU; ALU blocked by CDB slot 3 cycles later
    add(mk(0, 16'h0060, 16'h0020, 0, 0,  1, 4'd6, 0, 1));
    add(mk(0, 16'h0020, 16'h0020, 0, 0,  0, 4'd0, 0, 1));
    add(mk(0, 16'h0120, 16'h0020, 0, 0,  0, 4'd0, 0, 1));
    add(mk(0, 16'h0120, 16'h0020, 0, 0,  1, 4'd8, 0, 0));
    add(mk(0, 16'h0020, 16'h0020, 0, 0,  1, 4'd5, 1, 0));
    // Squash with a MULT in flight, then resume from idx 0 with an idle multiplier
    add(mk(0, 16'h0081, 16'h0000, 0, 1,  0, 4'd0, 0, 1));
    add(mk(0, 16'h0081, 16'h0001, 0, 0,  1, 4'd0, 1, 0));
    // ex_stall for 3 cycles: no issue, multiplier drains, rr_ptr holds
    add(mk(0, 16'h0006, 16'h0000, 1, 0,  0, 4'd0, 0, 1));
    add(mk(0, 16'h0006, 16'h0000, 1, 0,  0, 4'd0, 0, 1));
    add(mk(0, 16'h0006, 16'h0000, 1, 0,  0, 4'd0, 0, 1));
    add(mk(0, 16'h0006, 16'h0000, 0, 0,  1, 4'd1, 0, 0));
    // Wrap: issue 14, then 15, then 1, then rr_ptr=2 picks 2 over 1
    add(mk(0, 16'h4000, 16'h0000, 0, 0,  1, 4'd14, 0, 0));
    add(mk(0, 16'h8002, 16'h0000, 0, 0,  1, 4'd15, 0, 0));
    add(mk(0, 16'h0002, 16'h0000, 0, 0,  1, 4'd1, 0, 0));
    add(mk(0, 16'h0006, 16'h0000, 0, 0,  1, 4'd2, 0, 0));
    // Mid-run reset clears rr_ptr and multiplier state
    add(mk(1, 16'h0010, 16'h0010, 0, 0,  1, 4'd4, 1, 0));
    add(mk(0, 16'h0044, 16'h0044, 0, 0,  1, 4'd2, 1, 0));

    reset = 1'b1; rs_ready = '0; rs_is_mult = '0; ex_stall = 1'b0; squash = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    for (int i = 0; i < nvec; i++) begin
      reset      = vecs[i].rst;
      rs_ready   = vecs[i].ready;
      rs_is_mult = vecs[i].mult;
      ex_stall   = vecs[i].stall;
      squash     = vecs[i].sq;
      @(negedge clock);
      exp_clear = vecs[i].en ? (16'h0001 << vecs[i].idx) : 16'h0000;
      check("issue_en",      i, 32'(issue_en),      32'(vecs[i].en));
      check("issue_idx",     i, 32'(issue_idx),     32'(vecs[i].idx));
      check("issue_is_mult", i, 32'(issue_is_mult), 32'(vecs[i].ism));
      check("rs_clear",      i, 32'(rs_clear),      32'(exp_clear));
      check("mult_busy",     i, 32'(mult_busy),     32'(vecs[i].busy));
`ifdef ISSUE_SCHED_STATS_EN
      check("issue_count",   i, issue_count,          32'(m_issue));
      check("conflict_cnt",  i, conflict_stall_count, 32'(m_conflict));
`endif
      if (vecs[i].rst) begin
        m_issue = 0;
        m_conflict = 0;
      end else begin
        if (vecs[i].en) m_issue++;
        if ((vecs[i].ready != 16'h0) && !vecs[i].sq && !vecs[i].stall && !vecs[i].en) m_conflict++;
      end
      @(posedge clock);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
